// File: rtl/countdown_pkg.sv
// Shared types for the countdown controller: FSM state enum and the
// encoding exported on state_o.
package countdown_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_RUN   = 2'd1;
    localparam logic [1:0] ENC_PAUSE = 2'd2;
    localparam logic [1:0] ENC_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_RUN   = ENC_RUN,
        ST_PAUSE = ENC_PAUSE,
        ST_DONE  = ENC_DONE
    } state_t;

endpackage

// File: rtl/countdown_ctrl_if.sv
// Command/status bundle between the countdown controller and its user,
// plus the enable/reload/feedback lines of the down-counter.
interface countdown_ctrl_if #(
    parameter int BITS = 3
);
    logic            start;
    logic            pause;
    logic            abort;
    logic [BITS-1:0] cuenta;
    logic            en;
    logic            cnt_rst;
    logic            done;
    logic            busy;
    logic [1:0]      state_o;

    modport master (
        output start, pause, abort, cuenta,
        input  en, cnt_rst, done, busy, state_o
    );

    modport slave (
        input  start, pause, abort, cuenta,
        output en, cnt_rst, done, busy, state_o
    );
endinterface

// File: rtl/rise_edge.sv
// Rising-edge detector: registers the previous level and flags current & ~previous.
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) prev <= 1'b0;
        else      prev <= d;
    end

    assign rise = d & ~prev;
endmodule

// File: rtl/countdown_ctrl.sv
// Control FSM pacing a BITS-wide down-counter with prescaled enable pulses.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart automatically after each DONE cycle.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int BITS     = 3,
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    countdown_ctrl_if.slave bus
);
    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_TERM = PW'(TICK_DIV - 1);

    logic start_e, pause_e, abort_e;

    rise_edge u_start (.clk(clk), .rst(rst), .d(bus.start), .rise(start_e));
    rise_edge u_pause (.clk(clk), .rst(rst), .d(bus.pause), .rise(pause_e));
    rise_edge u_abort (.clk(clk), .rst(rst), .d(bus.abort), .rise(abort_e));

    state_t          state, state_n;
    logic [PW-1:0]   ps, ps_n;
    logic [BITS-1:0] cuenta;
    logic            tick, at_zero, en, busy, done_r;

    assign cuenta  = bus.cuenta;
    assign tick    = (ps == PS_TERM);
    assign at_zero = (cuenta == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            ps     <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            ps     <= ps_n;
            done_r <= (state_n == ST_DONE) && (state != ST_DONE);
        end
    end

    // Prescaler clears outside RUN/PAUSE so every RUN entry starts a full step.
    always_comb begin
        state_n = state;
        ps_n    = '0;
        en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!abort_e && start_e) state_n = ST_RUN;
            end
            ST_RUN: begin
                ps_n = tick ? '0 : ps + 1'b1;
                // The counter is never stepped past zero; the zero hold ends the run.
                en   = tick && !at_zero && !pause_e && !abort_e;
                if (abort_e)              state_n = ST_IDLE;
                else if (pause_e)         state_n = ST_PAUSE;
                else if (tick && at_zero) state_n = ST_DONE;
            end
            ST_PAUSE: begin
                ps_n = ps;
                if (abort_e)      state_n = ST_IDLE;
                else if (pause_e) state_n = ST_RUN;
            end
            ST_DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (abort_e) state_n = ST_IDLE;
                else         state_n = ST_RUN;
`else
                if (abort_e)      state_n = ST_IDLE;
                else if (start_e) state_n = ST_RUN;
`endif
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy        = (state == ST_RUN) || (state == ST_PAUSE);
    assign bus.en      = en;
    assign bus.busy    = busy;
    assign bus.cnt_rst = rst & busy;
    assign bus.done    = done_r;
    assign bus.state_o = state;
endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl with a behavioural 3-bit down-counter in the loop;
// expected done cycles are queued at start and matched when done pulses.
module tb_countdown_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    countdown_ctrl_if #(.BITS(3)) bus ();

    countdown_ctrl #(.BITS(3), .TICK_DIV(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Counter model: synchronous active-low reload to 7, decrement on en.
    always @(posedge clk) begin
        if (!bus.cnt_rst)  bus.cuenta <= 3'd7;
        else if (bus.en)   bus.cuenta <= bus.cuenta - 3'd1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int en_cnt  = 0;
    int exp_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: counts en pulses, matches done pulses against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.en === 1'b1) en_cnt++;
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) chk("done_unexpected_cycle", cyc, -1);
                else                   chk("done_cycle", cyc, exp_q.pop_front());
            end
            cyc++;
        end
    end

    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start pulse; done_off > 0 queues the expected done cycle relative to RUN entry.
    task automatic start_run(input int done_off, output int entry);
        if (done_off > 0) exp_q.push_back(cyc + 1 + done_off);
        bus.start = 1'b1;
        go(1);
        bus.start = 1'b0;
        entry = cyc;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        go(1);
        bus.abort = 1'b0;
        chk("abort_to_idle", bus.state_o, 0);
        go(1);
    endtask

    int e, en0;

    initial begin
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.abort = 1'b0;

        // 1: reset, then a full countdown
        go(2);
        chk("rst_state", bus.state_o, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_en", bus.en, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cnt_rst", bus.cnt_rst, 0);
        chk("rst_cuenta", bus.cuenta, 7);
        rst = 1'b1;
        go(1);
        en0 = en_cnt;
        start_run(32, e);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        exp_q.push_back(e + 65);
`endif
        for (int i = 0; i < 32; i++) begin
            chk("run_cuenta", bus.cuenta, 7 - i / 4);
            chk("run_state", bus.state_o, 1);
            go(1);
        end
        chk("done_state", bus.state_o, 3);
        chk("done_pulse", bus.done, 1);
        chk("run_en_pulses", en_cnt - en0, 7);
        go(1);
        chk("reload_cuenta", bus.cuenta, 7);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        chk("auto_rerun_state", bus.state_o, 1);
        go(32);
        chk("auto_done_state", bus.state_o, 3);
        chk("auto_done_pulse", bus.done, 1);
        chk("auto_cuenta_zero", bus.cuenta, 0);
`else
        chk("done_hold_state", bus.state_o, 3);
        chk("done_one_cycle", bus.done, 0);
        go(5);
        chk("done_persist", bus.state_o, 3);
`endif
        do_abort();

        // 2: pause 10 cycles in, resume 20 cycles later
        en0 = en_cnt;
        start_run(52, e);
        go(10);
        bus.pause = 1'b1;
        go(1);
        bus.pause = 1'b0;
        chk("pause_state", bus.state_o, 2);
        chk("pause_busy", bus.busy, 1);
        go(4);
        chk("pause_en", bus.en, 0);
        chk("pause_cuenta_a", bus.cuenta, 5);
        go(14);
        chk("pause_cuenta_b", bus.cuenta, 5);
        chk("pause_en_frozen", en_cnt - en0, 2);
        go(1);
        bus.pause = 1'b1;
        go(1);
        bus.pause = 1'b0;
        chk("resume_state", bus.state_o, 1);
        go(21);
        chk("pause_done_state", bus.state_o, 3);
        chk("pause_done_pulse", bus.done, 1);
        chk("pause_en_pulses", en_cnt - en0, 7);
        do_abort();

        // 3: abort while paused at cuenta=4
        start_run(0, e);
        go(12);
        chk("p3_cuenta", bus.cuenta, 4);
        bus.pause = 1'b1;
        go(1);
        bus.pause = 1'b0;
        chk("p3_pause", bus.state_o, 2);
        go(1);
        bus.abort = 1'b1;
        go(1);
        bus.abort = 1'b0;
        chk("p3_idle", bus.state_o, 0);
        chk("p3_cnt_rst", bus.cnt_rst, 0);
        chk("p3_busy", bus.busy, 0);
        chk("p3_cuenta_hold", bus.cuenta, 4);
        go(1);
        chk("p3_cuenta_reload", bus.cuenta, 7);
        go(2);

        // 4: pause and abort on a terminal prescaler cycle
        en0 = en_cnt;
        start_run(0, e);
        go(7);
        bus.pause = 1'b1;
        bus.abort = 1'b1;
        #1;
        chk("p4_en_suppressed", bus.en, 0);
        chk("p4_still_run", bus.state_o, 1);
        go(1);
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        chk("p4_abort_wins", bus.state_o, 0);
        chk("p4_cuenta", bus.cuenta, 6);
        go(1);
        chk("p4_cuenta_reload", bus.cuenta, 7);
        chk("p4_en_pulses", en_cnt - en0, 1);
        go(2);

        // 5: reset mid-run at cuenta=2
        start_run(0, e);
        go(21);
        chk("p5_cuenta", bus.cuenta, 2);
        rst = 1'b0;
        #1;
        chk("p5_cnt_rst_forced", bus.cnt_rst, 0);
        go(1);
        chk("p5_state", bus.state_o, 0);
        chk("p5_busy", bus.busy, 0);
        chk("p5_en", bus.en, 0);
        chk("p5_done", bus.done, 0);
        chk("p5_cuenta", bus.cuenta, 7);
        rst = 1'b1;
        go(3);
        chk("p5_stay_idle", bus.state_o, 0);
        chk("p5_cnt_rst", bus.cnt_rst, 0);

        chk("done_missing", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Control FSM that sits directly around the 3-bit down-counter with enable in the state-machine project. It paces the counter by issuing one-cycle `en` pulses from a clock prescaler. It watches the returned `cuenta` value to detect terminal count, and it reloads the counter by driving the counter's synchronous active-low reset. It handles start, pause and abort commands and reports completion to the rest of the design.

## Interface
- `BITS`, default 3: width of the counter value consumed on `cuenta`; must equal the counter's `BITS`.
- `TICK_DIV`, default 4: clock cycles per count step, ≥1; prescaler width is max(1, $clog2(TICK_DIV)).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  level command; its rising edge starts a countdown.
- `pause`  in  1  level command; its rising edge toggles RUN↔PAUSE.
- `abort`  in  1  level command; its rising edge returns the FSM to IDLE.
- `cuenta`  in  BITS  current counter value, fed back from the counter.
- `en`  out  1  enable to the counter; one-cycle decrement request.
- `cnt_rst`  out  1  active-low synchronous reset/reload to the counter, which loads 7.
- `done`  out  1  one-cycle pulse in the first cycle of DONE.
- `busy`  out  1  high in RUN and PAUSE.
- `state_o`  out  2  encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Edge detection: `start`, `pause` and `abort` are each registered (previous value). Edge = current & ~previous. Previous values reset to 0.
- Command priority in one cycle is abort > pause > start.
- IDLE:
  - `cnt_rst`=0, so the counter is held at 7. `en`=0.
  - On a start edge, go to RUN and clear the prescaler.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - At the terminal value (TICK_DIV-1) with `cuenta`≠0, assert `en` for that cycle.
  - At the terminal value with `cuenta`==0, do not assert `en` (the counter never wraps) and go to DONE.
  - On a pause edge, go to PAUSE. On an abort edge, go to IDLE.
  - `en` is suppressed in any cycle that carries a pause or abort edge.
- PAUSE:
  - `en`=0 and the prescaler value is frozen.
  - On a pause edge, return to RUN and resume from the frozen prescaler value.
  - On an abort edge, go to IDLE. Start edges are ignored.
- DONE:
  - `cnt_rst`=0 and `en`=0, so the counter reloads to 7 on the next edge.
  - A start edge goes to RUN with the prescaler cleared. An abort edge goes to IDLE. Pause edges are ignored.
- Start edges are ignored in RUN and PAUSE.
- Output decode:
  - `cnt_rst` = rst & (state ∈ {RUN, PAUSE}). It is forced low while `rst` is low.
  - `busy` = state ∈ {RUN, PAUSE}.
  - `en` is combinational from state, prescaler, `cuenta` and the edges.
  - `done` is registered.
- Reset values: state IDLE, prescaler 0, edge registers 0, `done`=0, `en`=0, `busy`=0, `cnt_rst`=0, `state_o`=0.
- Reset mid-operation aborts immediately; no done pulse is produced.

## Timing
- Each count value is held TICK_DIV cycles.
- RUN lasts 8·TICK_DIV cycles, covering 7 `en` pulses plus the final zero-hold interval.
- The `done` pulse occurs in the first DONE cycle, which is the 8·TICK_DIV-th cycle after RUN entry (RUN entry cycle counted as 0).
- Command-edge response: an input high at edge N is seen as an edge in cycle N, and the state changes at edge N+1.
- TICK_DIV=1: `en` is high every RUN cycle while `cuenta`≠0.
- Pause latency adds exactly the number of cycles spent in PAUSE.

## Configuration
- `COUNTDOWN_AUTO_RELOAD_EN` defined:
  - DONE lasts exactly one cycle, then the FSM enters RUN with the prescaler cleared (the counter has reloaded to 7).
  - `done` pulses periodically, with period 8·TICK_DIV+1.
  - An abort edge during DONE still goes to IDLE.
- Not defined: DONE persists until a start or abort edge.

## Structure
- `countdown_pkg` contains:
  - the state enum typedef (2 bits; IDLE, RUN, PAUSE, DONE);
  - the encoding constants used for `state_o`.
- Sub-module `rise_edge`: one register plus AND gate, active-low synchronous reset. It is instantiated three times.
- Top-level integration: the counter's `rst` connects to `cnt_rst`, its `EN` to `en`, and its `cuenta` back to `cuenta`.

## Test plan
All scenarios use BITS=3 and TICK_DIV=4, with the counter instantiated.

1. rst low 2 cycles, then start pulse → `cuenta` steps 7,6,…,0, each held 4 cycles; 7 `en` pulses; `done` high exactly at RUN-entry+32; afterwards `cuenta`=7, `state_o`=3.
2. Pause edge 10 cycles into RUN, second pause edge 20 cycles later → `en`=0 and `cuenta` frozen during PAUSE; `done` at RUN-entry+52.
3. Abort edge while in PAUSE with `cuenta`=4 → IDLE next cycle, `cnt_rst`=0, `busy`=0; `cuenta`=7 one edge later; no `done`.
4. Pause and abort edges in the same RUN cycle, on a terminal prescaler value → no `en` that cycle; state goes to IDLE (abort wins).
5. rst low mid-RUN at `cuenta`=2 → next cycle all outputs at reset values, `cnt_rst`=0, `cuenta`=7.
6. `COUNTDOWN_AUTO_RELOAD_EN` defined, single start → `done` pulses every 33 cycles, `state_o` shows 3 for one cycle each period, `cuenta` never wraps below 0.
